// File: rtl/sr_ff_pkg.sv
// Shared definitions for the SR flip-flop bank: S=R=1 resolution modes and the
// per-bit next-state function.
package sr_ff_pkg;

    localparam int unsigned SR_HOLD       = 0;
    localparam int unsigned SR_SET_WINS   = 1;
    localparam int unsigned SR_RESET_WINS = 2;
    localparam int unsigned SR_PRIO_COUNT = 3;

    // Next state of one SR bit; S=R=1 is resolved by prio, anything unknown holds.
    function automatic logic sr_next(
        input logic        q,
        input logic        s,
        input logic        r,
        input int unsigned prio
    );
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                if (prio == SR_SET_WINS) begin
                    nxt = 1'b1;
                end else if (prio == SR_RESET_WINS) begin
                    nxt = 1'b0;
                end else begin
                    nxt = q;
                end
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// Single SR storage bit with asynchronous active-high reset.
// Optional S=R=1 flag register enabled by SR_FF_INVALID_FLAG_EN.
module sr_ff_bit
    import sr_ff_pkg::*;
#(
    parameter int unsigned PRIO = SR_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
`ifdef SR_FF_INVALID_FLAG_EN
   ,output logic invalid
`endif
);

    logic state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= 1'b0;
        end else begin
            state <= sr_next(state, s, r, PRIO);
        end
    end

    assign q = state;

`ifdef SR_FF_INVALID_FLAG_EN
    // Flags the cycle after an edge that sampled the illegal S=R=1 pair.
    logic inv_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_flag <= 1'b0;
        end else begin
            inv_flag <= s & r;
        end
    end

    assign invalid = inv_flag;
`endif

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR flip-flops with complementary outputs.
// Define SR_FF_INVALID_FLAG_EN to add the registered per-bit S=R=1 flag output.
module sr_flip_flop
    import sr_ff_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SR_PRIORITY = SR_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
`ifdef SR_FF_INVALID_FLAG_EN
   ,output logic [WIDTH-1:0] invalid
`endif
);

    if (SR_PRIORITY >= SR_PRIO_COUNT) begin : g_bad_prio
        $error("sr_flip_flop: SR_PRIORITY must be 0 (hold), 1 (set wins) or 2 (reset wins)");
    end

    if (WIDTH == 0) begin : g_bad_width
        $error("sr_flip_flop: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        sr_ff_bit #(
            .PRIO (SR_PRIORITY)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .s       (s[i]),
            .r       (r[i]),
            .q       (q[i])
`ifdef SR_FF_INVALID_FLAG_EN
           ,.invalid (invalid[i])
`endif
        );
    end

    // Complement taken from the single state register so q and qb never agree.
    assign qb = ~q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Self-checking bench: three 4-bit banks, one per S=R=1 resolution mode, driven
// with shared stimulus and compared against a per-bit truth-table model.
module tb_sr_flip_flop;

    localparam int unsigned W = 4;
    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q_o   [N];
    logic [W-1:0] qb_o  [N];
    logic [W-1:0] inv_o [N];
    logic [W-1:0] mq    [N];
    logic [W-1:0] minv  [N];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < int'(N); g++) begin : g_dut
        sr_flip_flop #(
            .WIDTH       (W),
            .SR_PRIORITY (g)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .s       (s),
            .r       (r),
            .q       (q_o[g]),
            .qb      (qb_o[g])
`ifdef SR_FF_INVALID_FLAG_EN
           ,.invalid (inv_o[g])
`endif
        );
`ifndef SR_FF_INVALID_FLAG_EN
        assign inv_o[g] = '0;
`endif
    end

    // Truth table: 00 hold, 10 set, 01 clear, 11 resolved by the mode.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic [W-1:0] sv,
                                             input logic [W-1:0] rv, input int prio);
        logic [W-1:0] nxt;
        nxt = cur;
        for (int i = 0; i < int'(W); i++) begin
            if (sv[i] && !rv[i])      nxt[i] = 1'b1;
            else if (!sv[i] && rv[i]) nxt[i] = 1'b0;
            else if (sv[i] && rv[i])  nxt[i] = (prio == 1) ? 1'b1 : (prio == 2) ? 1'b0 : cur[i];
        end
        return nxt;
    endfunction

    task automatic drive(input logic [W-1:0] sv, input logic [W-1:0] rv);
        @(negedge clk);
        s = sv;
        r = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < int'(N); k++) begin
                mq[k]   = ref_next(mq[k], s, r, k);
                minv[k] = s & r;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(N); k++) begin
            mq[k]   = '0;
            minv[k] = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s   = '0;
        r   = '0;
        #2 rst = 1'b1;
        #1 model_reset();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== 4'h0) begin
                errors++; $display("FAIL reset_q dut%0d got %b want 0000", k, q_o[k]);
            end
            checks++;
            if (qb_o[k] !== 4'hF) begin
                errors++; $display("FAIL reset_qb dut%0d got %b want 1111", k, qb_o[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            tick();
            for (int k = 0; k < int'(N); k++) begin
                checks++;
                if (q_o[k] !== mq[k]) begin
                    errors++; $display("FAIL post_reset_hold dut%0d got %b want %b", k, q_o[k], mq[k]);
                end
            end
        end
    endtask

    task automatic test_set_reset();
        drive(4'hF, 4'h0);
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== 4'hF || qb_o[k] !== 4'h0) begin
                errors++; $display("FAIL set dut%0d q=%b qb=%b want 1111/0000", k, q_o[k], qb_o[k]);
            end
        end
        drive(4'h0, 4'hF);
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== 4'h0 || qb_o[k] !== 4'hF) begin
                errors++; $display("FAIL clear dut%0d q=%b qb=%b want 0000/1111", k, q_o[k], qb_o[k]);
            end
        end
        drive(4'h0, 4'h0);
        repeat (3) begin
            tick();
            for (int k = 0; k < int'(N); k++) begin
                checks++;
                if (q_o[k] !== mq[k]) begin
                    errors++; $display("FAIL hold_zero dut%0d got %b want %b", k, q_o[k], mq[k]);
                end
            end
        end
    endtask

    task automatic test_hold_after_set();
        drive(4'hF, 4'h0);
        tick();
        drive(4'h0, 4'h0);
        repeat (5) begin
            tick();
            for (int k = 0; k < int'(N); k++) begin
                checks++;
                if (q_o[k] !== 4'hF || qb_o[k] !== 4'h0) begin
                    errors++; $display("FAIL hold_one dut%0d q=%b qb=%b want 1111/0000", k, q_o[k], qb_o[k]);
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [W-1:0] want [N];
        want[0] = 4'hF;
        want[1] = 4'hF;
        want[2] = 4'h0;
        drive(4'hF, 4'h0);
        tick();
        drive(4'hF, 4'hF);
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== want[k] || qb_o[k] !== ~want[k]) begin
                errors++; $display("FAIL both_high prio%0d q=%b qb=%b want q=%b", k, q_o[k], qb_o[k], want[k]);
            end
`ifdef SR_FF_INVALID_FLAG_EN
            checks++;
            if (inv_o[k] !== 4'hF) begin
                errors++; $display("FAIL invalid_set prio%0d got %b want 1111", k, inv_o[k]);
            end
`endif
        end
        drive(4'h0, 4'h0);
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== want[k]) begin
                errors++; $display("FAIL both_high_after prio%0d got %b want %b", k, q_o[k], want[k]);
            end
`ifdef SR_FF_INVALID_FLAG_EN
            checks++;
            if (inv_o[k] !== 4'h0) begin
                errors++; $display("FAIL invalid_clear prio%0d got %b want 0000", k, inv_o[k]);
            end
`endif
        end
    endtask

    task automatic test_async_override();
        drive(4'hF, 4'h0);
        tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 model_reset();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== 4'h0 || qb_o[k] !== 4'hF) begin
                errors++; $display("FAIL async_rst dut%0d q=%b qb=%b want 0000/1111", k, q_o[k], qb_o[k]);
            end
        end
        #1 rst = 1'b0;
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== 4'hF) begin
                errors++; $display("FAIL async_rst_resume dut%0d got %b want 1111", k, q_o[k]);
            end
        end
    endtask

    task automatic test_multibit();
        drive(4'h0, 4'hF);
        tick();
        drive(4'b1010, 4'b0101);
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (q_o[k] !== 4'b1010 || qb_o[k] !== 4'b0101) begin
                errors++; $display("FAIL multibit dut%0d q=%b qb=%b want 1010/0101", k, q_o[k], qb_o[k]);
            end
        end
    endtask

    task automatic test_random();
        repeat (300) begin
            drive(W'($urandom), W'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                #1 rst = 1'b1;
                #1 model_reset();
                for (int k = 0; k < int'(N); k++) begin
                    checks++;
                    if (q_o[k] !== mq[k]) begin
                        errors++; $display("FAIL rand_rst dut%0d got %b want %b", k, q_o[k], mq[k]);
                    end
                end
                #1 rst = 1'b0;
            end
            tick();
            for (int k = 0; k < int'(N); k++) begin
                checks++;
                if (q_o[k] !== mq[k] || qb_o[k] !== ~mq[k]) begin
                    errors++; $display("FAIL rand dut%0d q=%b qb=%b want q=%b", k, q_o[k], qb_o[k], mq[k]);
                end
`ifdef SR_FF_INVALID_FLAG_EN
                checks++;
                if (inv_o[k] !== minv[k]) begin
                    errors++; $display("FAIL rand_invalid dut%0d got %b want %b", k, inv_o[k], minv[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_hold_after_set();
        test_invalid();
        test_async_override();
        test_multibit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
